// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch initiator with 2-entry buffer, redirect and fault detection
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_en              enables fetching
//   imem_addr, imem_data  byte address to / word from combinational instruction memory
//   redirect_valid/pc     single-cycle PC redirect request and target
//   instr_valid/ready     head-entry handshake towards decode
//   instr_data, instr_pc  head instruction word and its byte address
//   fault, fault_pc       fault state flag and captured offending address
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] tail_data;
  logic [31:0] tail_pc;
  logic [1:0]  count;

  logic pop;
  logic out_of_range;
  logic fetch_edge;
  logic push;

  assign imem_addr   = pc;
  assign instr_valid = (count != 2'd0);

  // Head entry lives directly in instr_data/instr_pc, so they hold when empty.
  assign pop          = (count != 2'd0) && instr_ready;
  assign out_of_range = {2'b00, pc[31:2]} >= 32'(MEM_WORDS);
  assign fetch_edge   = (state == RUN) && fetch_en && !redirect_valid;
  // A pop on the same edge frees a slot, so a full buffer can still accept.
  assign push         = fetch_edge && !out_of_range && ((count != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      count      <= 2'd0;
      instr_data <= 32'd0;
      instr_pc   <= 32'd0;
      tail_data  <= 32'd0;
      tail_pc    <= 32'd0;
      fault      <= 1'b0;
      fault_pc   <= 32'd0;
    end else if (redirect_valid) begin
      // Redirect wins in every state; any head handshake this edge is simply dropped with the flush.
      count <= 2'd0;
      pc    <= redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state    <= FAULT;
        fault    <= 1'b1;
        fault_pc <= redirect_pc;
      end else begin
        fault <= 1'b0;
        state <= fetch_en ? RUN : IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) state <= RUN;
        end
        RUN: begin
          if (!fetch_en) begin
            state <= IDLE;
          end else if (out_of_range) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= pc;
          end
        end
        FAULT: begin
        end
        default: state <= IDLE;
      endcase

      if (push) pc <= pc + 32'd4;

      case ({push, pop})
        2'b11: begin
          if (count == 2'd2) begin
            instr_data <= tail_data;
            instr_pc   <= tail_pc;
            tail_data  <= imem_data;
            tail_pc    <= pc;
          end else begin
            instr_data <= imem_data;
            instr_pc   <= pc;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            instr_data <= tail_data;
            instr_pc   <= tail_pc;
          end
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            instr_data <= imem_data;
            instr_pc   <= pc;
          end else begin
            tail_data <= imem_data;
            tail_pc   <= pc;
          end
          count <= count + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
